// File: rtl/sw_pkg.sv
// sw_pkg: shared state encoding and BCD limits for the stopwatch time counter.
package sw_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP_HOLD = 2'd3} state_t;
  localparam int BCD_W = 8;
  localparam int HS_MAX = 99;
  localparam int SEC_MAX = 59;
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter that rolls over at MAX, with enable, sync clear and carry out.
module bcd_mod_counter
  import sw_pkg::*;
#(
  parameter int MAX = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             co
);
  localparam logic [BCD_W-1:0] MAX_BCD = {4'(MAX / 10), 4'(MAX % 10)};
  assign co = en && q == MAX_BCD;
  always_ff @(posedge clk)
    if (!rst || clr) q <= '0;
    else if (en) q <= co ? '0 : q[3:0] == 4'd9 ? {q[7:4] + 4'd1, 4'd0} : {q[7:4], q[3:0] + 4'd1};
endmodule

// File: rtl/sw_time_counter.sv
// sw_time_counter: stopwatch state machine, mm:ss.hh BCD count chain and lap latch.
module sw_time_counter
  import sw_pkg::*;
#(
  parameter int WRAP_MIN = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             btn_start,
  input  logic             btn_lap,
  input  logic             btn_clear,
  output logic             run_en,
  output logic [BCD_W-1:0] disp_min,
  output logic [BCD_W-1:0] disp_sec,
  output logic [BCD_W-1:0] disp_hs,
  output logic [1:0]       state_o,
  output logic             wrap
);
  state_t state, nxt;
  logic tick_q, tick_pulse, inc, clr, hs_co, sec_co, min_co;
  logic [BCD_W-1:0] hs, sec, mn, lap_hs, lap_sec, lap_min;
  assign tick_pulse = tick_in & ~tick_q;
  assign run_en = state == RUN || state == LAP_HOLD;
  // a start pulse wins the cycle, so a coincident tick is dropped
  assign inc = tick_pulse & run_en & ~btn_start;
  assign clr = state == PAUSE && btn_clear;
  assign state_o = state;
  always_comb begin
    nxt = state;
    if (clr) nxt = IDLE;
    else if (btn_start) nxt = (state == IDLE || state == PAUSE) ? RUN : PAUSE;
    else if (btn_lap) nxt = state == RUN ? LAP_HOLD : state == LAP_HOLD ? RUN : state;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      tick_q <= 1'b0;
      wrap <= 1'b0;
      {lap_min, lap_sec, lap_hs} <= '0;
    end else begin
      state <= nxt;
      tick_q <= tick_in;
      wrap <= min_co;
      if (clr) {lap_min, lap_sec, lap_hs} <= '0;
      else if (nxt == LAP_HOLD && state != LAP_HOLD) {lap_min, lap_sec, lap_hs} <= {mn, sec, hs};
    end
  bcd_mod_counter #(.MAX(HS_MAX)) u_hs (.clk(clk), .rst(rst), .en(inc), .clr(clr), .q(hs), .co(hs_co));
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (.clk(clk), .rst(rst), .en(hs_co), .clr(clr), .q(sec), .co(sec_co));
  bcd_mod_counter #(.MAX(WRAP_MIN)) u_min (.clk(clk), .rst(rst), .en(sec_co), .clr(clr), .q(mn), .co(min_co));
  assign {disp_min, disp_sec, disp_hs} = state == LAP_HOLD ? {lap_min, lap_sec, lap_hs} : {mn, sec, hs};
endmodule

// File: tb/tb_sw_time_counter.sv
// tb_sw_time_counter: directed and random stimulus against an arithmetic stopwatch model.
module tb_sw_time_counter;
  localparam int WRAP_MIN = 1;
  localparam int MOD = (WRAP_MIN + 1) * 6000;
  logic clk = 0, rst = 0, tick_in = 0, btn_start = 0, btn_lap = 0, btn_clear = 0;
  logic run_en, wrap;
  logic [7:0] disp_min, disp_sec, disp_hs;
  logic [1:0] state_o;
  int vectors = 0, fails = 0;
  int m_state = 0, m_cnt = 0, m_lap = 0;
  bit m_tq = 0, m_wrap = 0;

  sw_time_counter #(.WRAP_MIN(WRAP_MIN)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .run_en(run_en), .disp_min(disp_min), .disp_sec(disp_sec),
    .disp_hs(disp_hs), .state_o(state_o), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int x);
    return 8'((x / 10) * 16 + x % 10);
  endfunction

  function automatic logic [23:0] shown(input int v);
    return {bcd(v / 6000), bcd((v / 100) % 60), bcd(v % 100)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // model: time kept as total hundredths, states as 0..3 per the output encoding
  task automatic step(input bit t, input bit s, input bit l, input bit c, input bit r = 1);
    int nst, old;
    bit pulse, running;
    tick_in = t; btn_start = s; btn_lap = l; btn_clear = c; rst = r;
    @(posedge clk);
    if (!r) begin
      m_state = 0; m_cnt = 0; m_lap = 0; m_tq = 0; m_wrap = 0;
    end else begin
      pulse = t && !m_tq;
      m_tq = t;
      running = m_state == 1 || m_state == 3;
      old = m_cnt;
      m_wrap = 0;
      if (pulse && running && !s) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == MOD) begin m_cnt = 0; m_wrap = 1; end
      end
      nst = m_state;
      if (c && m_state == 2) begin nst = 0; m_cnt = 0; m_lap = 0; end
      else if (s) nst = (m_state == 0 || m_state == 2) ? 1 : 2;
      else if (l && m_state == 1) nst = 3;
      else if (l && m_state == 3) nst = 1;
      if (nst == 3 && m_state != 3) m_lap = old;
      m_state = nst;
    end
    #1;
    chk("cycle", {4'd0, state_o, run_en, wrap, disp_min, disp_sec, disp_hs},
        {4'd0, 2'(m_state), (m_state == 1 || m_state == 3), m_wrap, shown(m_state == 3 ? m_lap : m_cnt)});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("reset_state", {state_o, run_en, wrap}, 4'b0000);
    chk("reset_disp", {disp_min, disp_sec, disp_hs}, 24'h000000);
    step(0, 1, 0, 0);
    ticks(100);
    chk("one_sec", {run_en, disp_min, disp_sec, disp_hs}, {1'b1, 24'h000100});
    ticks(420);
    step(0, 0, 1, 0);
    ticks(30);
    chk("lap_hold", {state_o, disp_min, disp_sec, disp_hs}, {2'd3, 24'h000520});
    step(0, 0, 1, 0);
    chk("lap_release", {state_o, disp_min, disp_sec, disp_hs}, {2'd1, 24'h000550});
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    ticks(200);
    step(0, 1, 0, 0);
    ticks(50);
    chk("paused", {state_o, disp_min, disp_sec, disp_hs}, {2'd2, 24'h000200});
    step(0, 1, 0, 0);
    ticks(1);
    chk("resumed", {state_o, disp_min, disp_sec, disp_hs}, {2'd1, 24'h000201});
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("clear_wins", {state_o, run_en, disp_min, disp_sec, disp_hs}, {2'd0, 1'b0, 24'h000000});
    step(0, 1, 0, 0);
    ticks(5);
    step(0, 0, 0, 1);
    chk("clear_in_run", {state_o, disp_min, disp_sec, disp_hs}, {2'd1, 24'h000005});
    ticks(342);
    chk("at_3_47", {disp_min, disp_sec, disp_hs}, 24'h000347);
    step(1, 0, 0, 0, 0);
    chk("mid_reset", {state_o, run_en, disp_min, disp_sec, disp_hs}, {2'd0, 1'b0, 24'h000000});
    step(0, 1, 0, 0);
    ticks(MOD - 1);
    chk("before_wrap", {wrap, disp_min, disp_sec, disp_hs}, {1'b0, 8'(WRAP_MIN), 16'h5999});
    step(1, 0, 0, 0);
    chk("wrap_pulse", {wrap, disp_min, disp_sec, disp_hs}, {1'b1, 24'h000000});
    step(0, 0, 0, 0);
    chk("wrap_single", {4'd0, wrap}, 5'd0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 299) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/sw_time_counter.md
SW_TIME_COUNTER -- requirements
Module: sw_time_counter

Interface
REQ-001 Parameter WRAP_MIN, default 59, highest minute value before the count rolls over to 00:00.00.
REQ-002 clk  input  1  system clock; every flop in the block runs on clk.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 tick_in  input  1  divided square wave from the stopwatch clock divider, 100 Hz nominal; sampled on clk and never used as a clock.
REQ-005 btn_start  input  1  start/stop request; debounced, one-cycle pulse.
REQ-006 btn_lap  input  1  lap request; debounced, one-cycle pulse.
REQ-007 btn_clear  input  1  clear request; debounced, one-cycle pulse.
REQ-008 run_en  output  1  high while counting; drives the divider's stop (enable) input.
REQ-009 disp_min  output  8  BCD minutes shown on the display, 00..WRAP_MIN.
REQ-010 disp_sec  output  8  BCD seconds shown on the display, 00..59.
REQ-011 disp_hs  output  8  BCD hundredths shown on the display, 00..99.
REQ-012 state_o  output  2  current state: IDLE=0, RUN=1, PAUSE=2, LAP_HOLD=3.
REQ-013 wrap  output  1  one-cycle pulse on rollover from WRAP_MIN:59.99 to 00:00.00.

Function
REQ-014 Tick detect: tick_q is the previous sample of tick_in, updated every cycle in every state; tick_pulse = tick_in & ~tick_q.
REQ-015 The live count advances by 0.01 s on the clock edge at which tick_pulse is high and state is RUN or LAP_HOLD; new value is visible on the next cycle.
REQ-016 tick_pulse in IDLE or PAUSE is discarded; resuming never produces a catch-up increment.
REQ-017 Count chain: hs 99->00 carries into sec; sec 59->00 carries into min; min WRAP_MIN->00 asserts wrap for exactly one cycle.
REQ-018 All digits are valid BCD at all times; no digit ever holds a value above 9.
REQ-019 FSM: IDLE+start->RUN; RUN+start->PAUSE; RUN+lap->LAP_HOLD; LAP_HOLD+lap->RUN; LAP_HOLD+start->PAUSE; PAUSE+start->RUN; PAUSE+clear->IDLE.
REQ-020 Any other button/state combination leaves the state unchanged; clear in RUN or LAP_HOLD is ignored.
REQ-021 Simultaneous pulses resolve with priority clear > start > lap; only the winner takes effect in that cycle.
REQ-022 Entering IDLE through clear zeroes the live count and the lap latch on the same edge.
REQ-023 Entering LAP_HOLD copies the live count into the lap latch; the display outputs show the lap latch while in LAP_HOLD and the live count in every other state.
REQ-024 Counting continues in LAP_HOLD; leaving LAP_HOLD shows the live count from the next cycle.
REQ-025 A tick_pulse that coincides with a start pulse in RUN does not increment; a tick_pulse that coincides with start in PAUSE does not increment either.
REQ-026 run_en = 1 exactly when state is RUN or LAP_HOLD, decoded from registered state.

Reset
REQ-027 While rst = 0 at a clk edge: state is IDLE, all counters and the lap latch are 00, tick_q is 0, and wrap and run_en are 0.
REQ-028 Reset asserted mid-count overrides every button and tick in that cycle; the first increment after release requires a fresh tick_in rising edge.

Structure
REQ-029 Package sw_pkg holds the state encoding, BCD_W=8, HS_MAX=99 and SEC_MAX=59.
REQ-030 Sub-module bcd_mod_counter (two-digit BCD counter with parameterized modulus, enable, synchronous clear and carry out) is instantiated three times, for hs, sec and min.

Verification
REQ-031 Reset, start, 100 tick_in rising edges -> disp shows 00:01.00 and run_en = 1.
REQ-032 Preload 59:59.99 in RUN, one tick -> 00:00.00 and wrap high for exactly one cycle.
REQ-033 Lap at 00:05.20, 30 further ticks -> display holds 00:05.20; second lap -> display shows 00:05.50.
REQ-034 Start (pause) at 00:02.00, tick_in keeps toggling for 50 periods -> count stays 00:02.00; start again plus one tick -> 00:02.01.
REQ-035 In PAUSE, clear and start in the same cycle -> state IDLE with all digits 00; clear in RUN -> ignored.
REQ-036 rst low for one cycle while running at 00:03.47 -> 00:00.00, IDLE, run_en = 0 on the next cycle.
